// File: rtl/qmax_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : qmax_pkg                                                |
// | Description: Shared encodings and default widths for the Q-max      |
// |              read-modify-write table.                                |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package qmax_pkg;

  // Table control states: sweeping zeros into storage, or serving requests
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } qmax_state_t;

  // Update mode encodings for i_upd_mode
  localparam logic UPD_OVERWRITE = 1'b0;
  localparam logic UPD_MAX       = 1'b1;

  // Default geometry
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_NUM_RD     = 2;
  localparam int DEF_ACT_WIDTH  = 2;

endpackage : qmax_pkg
`default_nettype wire

// File: rtl/qmax_merge_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : qmax_merge_unit                                         |
// | Description: Combinational update resolver. Chooses the new entry    |
// |              value (overwrite or signed max) and flags whether it    |
// |              differs from the stored value.                          |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module qmax_merge_unit
  import qmax_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] stored_val,
  input  logic [DATA_WIDTH-1:0] upd_val,
  output logic [DATA_WIDTH-1:0] new_val,
  output logic                  changed
);

  // Select the resulting value; ties in max mode keep the stored value
  always_comb begin
    new_val = upd_val;
    case (mode)
      UPD_OVERWRITE: new_val = upd_val;
      UPD_MAX:       new_val = ($signed(upd_val) > $signed(stored_val)) ? upd_val : stored_val;
      default:       new_val = upd_val;
    endcase
    changed = (new_val != stored_val);
  end

endmodule : qmax_merge_unit
`default_nettype wire

// File: rtl/qmax_rmw_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : qmax_rmw_table                                          |
// | Description: Multi-port Q-max table. NUM_RD registered read ports,   |
// |              one 2-stage read-modify-write update port (overwrite or |
// |              signed max-merge), and a counter-driven clear sweep     |
// |              after reset that gates o_ready.                         |
// |              Optional macro QMAX_ARGMAX_EN adds a stored action      |
// |              index per entry (i_upd_act / o_rd_act).                 |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module qmax_rmw_table
  import qmax_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_RD     = DEF_NUM_RD
`ifdef QMAX_ARGMAX_EN
  ,
  parameter int ACT_WIDTH  = DEF_ACT_WIDTH
`endif
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_RD-1:0]            i_rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
  output logic [NUM_RD-1:0]            o_rd_valid,
  input  logic                         i_upd_valid,
  input  logic                         i_upd_mode,
  input  logic [ADDR_WIDTH-1:0]        i_upd_addr,
  input  logic [DATA_WIDTH-1:0]        i_upd_data,
  output logic                         o_ready,
  output logic                         o_upd_done,
  output logic                         o_upd_changed
`ifdef QMAX_ARGMAX_EN
  ,
  input  logic [ACT_WIDTH-1:0]         i_upd_act,
  output logic [NUM_RD*ACT_WIDTH-1:0]  o_rd_act
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // ------------------------------------------------------------------
  // Control state and clear sweep
  // ------------------------------------------------------------------
  qmax_state_t           state;
  qmax_state_t           state_next;
  logic [ADDR_WIDTH-1:0] clear_cnt;
  logic [ADDR_WIDTH-1:0] clear_cnt_next;
  logic                  ready;

  // State and sweep counter registers; reset always restarts the sweep
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_CLEAR;
      clear_cnt <= '0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_cnt_next;
    end
  end

  // Advance the sweep one entry per cycle and hand over to RUN after the last
  always_comb begin
    state_next     = state;
    clear_cnt_next = clear_cnt;
    case (state)
      ST_CLEAR: begin
        if (clear_cnt == LAST_ADDR) begin
          state_next = ST_RUN;
        end else begin
          clear_cnt_next = clear_cnt + 1'b1;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_CLEAR;
    endcase
  end

  assign ready   = (state == ST_RUN);
  assign o_ready = ready;

  // ------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ------------------------------------------------------------------
  // Update pipeline
  // ------------------------------------------------------------------
  logic                  s1_valid;
  logic                  s1_mode;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] s1_stored;

  logic                  s2_valid;
  logic                  s2_mode;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [DATA_WIDTH-1:0] s2_stored;
  logic [DATA_WIDTH-1:0] s2_new;
  logic                  s2_changed;
  logic                  s2_we;

`ifdef QMAX_ARGMAX_EN
  logic [ACT_WIDTH-1:0]  mem_act [DEPTH];
  logic [ACT_WIDTH-1:0]  s1_act;
  logic [ACT_WIDTH-1:0]  s2_act;
`endif

  // Pipeline valid bits; reset drops anything in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= i_upd_valid & ready;
      s2_valid <= s1_valid;
    end
  end

  // Pipeline payload registers, loaded only when their stage is fed
  always_ff @(posedge i_clk) begin
    if (i_upd_valid && ready) begin
      s1_mode <= i_upd_mode;
      s1_addr <= i_upd_addr;
      s1_data <= i_upd_data;
`ifdef QMAX_ARGMAX_EN
      s1_act  <= i_upd_act;
`endif
    end
    if (s1_valid) begin
      s2_mode   <= s1_mode;
      s2_addr   <= s1_addr;
      s2_data   <= s1_data;
      s2_stored <= s1_stored;
`ifdef QMAX_ARGMAX_EN
      s2_act    <= s1_act;
`endif
    end
  end

  // S1 stored-value fetch; forward the S2 result when it is about to write the same entry
  always_comb begin
    s1_stored = mem[s1_addr];
    if (s2_we && (s2_addr == s1_addr)) begin
      s1_stored = s2_new;
    end
  end

  qmax_merge_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .mode       (s2_mode),
    .stored_val (s2_stored),
    .upd_val    (s2_data),
    .new_val    (s2_new),
    .changed    (s2_changed)
  );

  // Unchanged results skip the write; memory already holds the value
  assign s2_we         = s2_valid & s2_changed;
  assign o_upd_done    = s2_valid & ~i_rst;
  assign o_upd_changed = s2_we & ~i_rst;

  // Single write port shared by the clear sweep and the S2 commit
  always_ff @(posedge i_clk) begin
    if (state == ST_CLEAR) begin
      mem[clear_cnt] <= '0;
`ifdef QMAX_ARGMAX_EN
      mem_act[clear_cnt] <= '0;
`endif
    end else if (s2_we && !i_rst) begin
      mem[s2_addr] <= s2_new;
`ifdef QMAX_ARGMAX_EN
      mem_act[s2_addr] <= s2_act;
`endif
    end
  end

  // ------------------------------------------------------------------
  // Read ports
  // ------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] rd_addr_w [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_next   [NUM_RD];
`ifdef QMAX_ARGMAX_EN
  logic [ACT_WIDTH-1:0]  rd_act_next [NUM_RD];
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign rd_addr_w[k] = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    // Write-first: a read colliding with the S2 commit sees the new value
    assign rd_next[k]   = (s2_we && (s2_addr == rd_addr_w[k])) ? s2_new : mem[rd_addr_w[k]];
`ifdef QMAX_ARGMAX_EN
    assign rd_act_next[k] = (s2_we && (s2_addr == rd_addr_w[k])) ? s2_act : mem_act[rd_addr_w[k]];
`endif
  end

  // Registered read data per port; data holds when the port is idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_valid <= '0;
      o_rd_data  <= '0;
`ifdef QMAX_ARGMAX_EN
      o_rd_act   <= '0;
`endif
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        o_rd_valid[k] <= i_rd_en[k] & ready;
        if (i_rd_en[k] && ready) begin
          o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= rd_next[k];
`ifdef QMAX_ARGMAX_EN
          o_rd_act[k*ACT_WIDTH +: ACT_WIDTH]    <= rd_act_next[k];
`endif
        end
      end
    end
  end

endmodule : qmax_rmw_table
`default_nettype wire

// File: tb/tb_qmax_rmw_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_qmax_rmw_table                                       |
// | Description: Self-checking bench for qmax_rmw_table. Directed steps  |
// |              plus random traffic checked against a serial table      |
// |              model with commit-time bookkeeping.                     |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_qmax_rmw_table;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int NRD = 2;

  logic              clk;
  logic              rst;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_valid;
  logic              upd_valid;
  logic              upd_mode;
  logic [AW-1:0]     upd_addr;
  logic [DW-1:0]     upd_data;
  logic              ready;
  logic              upd_done;
  logic              upd_changed;
`ifdef QMAX_ARGMAX_EN
  logic [1:0]        upd_act;
  logic [NRD*2-1:0]  rd_act;
`endif

  qmax_rmw_table dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rd_en       (rd_en),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .i_upd_valid   (upd_valid),
    .i_upd_mode    (upd_mode),
    .i_upd_addr    (upd_addr),
    .i_upd_data    (upd_data),
    .o_ready       (ready),
    .o_upd_done    (upd_done),
    .o_upd_changed (upd_changed)
`ifdef QMAX_ARGMAX_EN
    ,
    .i_upd_act     (upd_act),
    .o_rd_act      (rd_act)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the logical table applies updates serially at
  // acceptance; the committed table becomes visible to reads two edges later.
  typedef struct {
    int          addr;
    logic [31:0] val;
    logic        chg;
    int          commit;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] log_mem [DEPTH];
  logic [31:0] com_mem [DEPTH];
  logic [31:0] exp_data [NRD];
  logic        exp_valid [NRD];
  int          edge_n = 0;
  int          clr_edges = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          done_cnt = 0;
  logic        obs_chg;
  int          zeros;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    rd_en     = '0;
    rd_addr   = '0;
    upd_valid = 1'b0;
    upd_mode  = 1'b0;
    upd_addr  = '0;
    upd_data  = '0;
`ifdef QMAX_ARGMAX_EN
    upd_act   = '0;
`endif
  endtask

  task automatic drive_random();
    rd_en = NRD'($urandom_range(0, 3));
    for (int k = 0; k < NRD; k++) begin
      rd_addr[k*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
    end
    upd_valid = ($urandom_range(0, 3) != 0);
    upd_mode  = $urandom_range(0, 1) == 1;
    upd_addr  = AW'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) upd_data = $urandom;
    else upd_data = DW'(int'($urandom_range(0, 64)) - 32);
`ifdef QMAX_ARGMAX_EN
    upd_act = 2'($urandom_range(0, 3));
`endif
  endtask

  // One clock: predict the effect of the coming edge, then check every output
  task automatic step();
    int          n;
    bit          rdy;
    logic [31:0] cur;
    logic [31:0] nv;
    pend_t       p;
    logic        exp_done;
    logic        exp_chg;
    n = edge_n + 1;
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        log_mem[a] = '0;
        com_mem[a] = '0;
      end
      pend.delete();
      clr_edges = 0;
      for (int k = 0; k < NRD; k++) begin
        exp_valid[k] = 1'b0;
        exp_data[k]  = '0;
      end
    end else begin
      rdy = (clr_edges >= DEPTH);
      while (pend.size() > 0 && pend[0].commit == n) begin
        com_mem[pend[0].addr] = pend[0].val;
        void'(pend.pop_front());
      end
      for (int k = 0; k < NRD; k++) begin
        if (rd_en[k] && rdy) begin
          exp_valid[k] = 1'b1;
          exp_data[k]  = com_mem[int'(rd_addr[k*AW +: AW])];
        end else begin
          exp_valid[k] = 1'b0;
        end
      end
      if (upd_valid && rdy) begin
        cur = log_mem[int'(upd_addr)];
        if (upd_mode) nv = ($signed(upd_data) > $signed(cur)) ? upd_data : cur;
        else nv = upd_data;
        p.addr   = int'(upd_addr);
        p.val    = nv;
        p.chg    = (nv != cur);
        p.commit = n + 2;
        pend.push_back(p);
        log_mem[int'(upd_addr)] = nv;
      end
      if (clr_edges < 1000) clr_edges++;
    end
    @(posedge clk);
    #1;
    edge_n = n;
    check("ready", ready, (clr_edges >= DEPTH));
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("rd_valid%0d", k), rd_valid[k], exp_valid[k]);
      check($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], exp_data[k]);
    end
    exp_done = (pend.size() > 0) && (pend[0].commit == n + 1);
    exp_chg  = exp_done ? pend[0].chg : 1'b0;
    check("upd_done", upd_done, exp_done);
    check("upd_changed", upd_changed, exp_chg);
    if (upd_done === 1'b1) done_cnt++;
    obs_chg = upd_changed;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Count observed not-ready cycles from the reset edge until o_ready rises
  task automatic wait_ready(input bit noise, output int nz);
    nz = (ready === 1'b0) ? 1 : 0;
    for (int i = 0; i < 200 && ready !== 1'b1; i++) begin
      if (noise) drive_random();
      else clear_in();
      step();
      if (ready !== 1'b1) nz++;
    end
    clear_in();
    check("ready_rise", ready, 1'b1);
    check("sweep_len", nz, DEPTH);
  endtask

  task automatic upd(input logic mode, input int addr, input logic [31:0] data);
    clear_in();
    upd_valid = 1'b1;
    upd_mode  = mode;
    upd_addr  = AW'(addr);
    upd_data  = data;
    step();
    clear_in();
  endtask

  initial begin
    rst = 1'b0;
    clear_in();

    // Reset, then random requests during the sweep must leave no trace
    pulse_rst();
    check("rst_ready", ready, 1'b0);
    check("rst_rd_valid", rd_valid, '0);
    check("rst_done", upd_done, 1'b0);
    wait_ready(1'b1, zeros);

    // Every entry reads back as zero
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 2'b11;
      rd_addr[0 +: AW]  = AW'(a);
      rd_addr[AW +: AW] = AW'(DEPTH - 1 - a);
      step();
    end
    clear_in();
    step();

    // Overwrite addr 5, read on port 1 three cycles later
    upd(1'b0, 5, 32'h10);
    step();
    step();
    rd_en = 2'b10;
    rd_addr[AW +: AW] = AW'(5);
    step();
    clear_in();
    check("rd5_valid", rd_valid[1], 1'b1);
    check("rd5_data", rd_data[DW +: DW], 32'h10);
    step();
    check("rd5_valid_drop", rd_valid[1], 1'b0);

    // Max-merge sequence on addr 7, issued back to back
    upd(1'b0, 7, 32'h20);
    upd(1'b1, 7, 32'h10);
    check("a7_chg_ovw", obs_chg, 1'b1);
    upd(1'b1, 7, 32'h30);
    check("a7_chg_max10", obs_chg, 1'b0);
    upd(1'b1, 7, 32'hFFFF_FFFF);
    check("a7_chg_max30", obs_chg, 1'b1);
    step();
    check("a7_chg_maxm1", obs_chg, 1'b0);
    step();
    rd_en = 2'b01;
    rd_addr[0 +: AW] = AW'(7);
    step();
    clear_in();
    check("a7_final", rd_data[0 +: DW], 32'h30);

    // Back-to-back max updates to addr 3 with a bypass read on the 0x09 commit
    upd(1'b1, 3, 32'h05);
    upd(1'b1, 3, 32'h09);
    check("a3_chg1", obs_chg, 1'b1);
    upd(1'b1, 3, 32'h07);
    check("a3_chg2", obs_chg, 1'b1);
    rd_en = 2'b01;
    rd_addr[0 +: AW] = AW'(3);
    step();
    clear_in();
    check("a3_chg3", obs_chg, 1'b0);
    check("a3_bypass", rd_data[0 +: DW], 32'h09);
    step();
    step();

    // Random mixed traffic on a small address window
    for (int i = 0; i < 300; i++) begin
      drive_random();
      step();
    end
    clear_in();
    step();
    step();

    // Reset at cycle 20 of a sweep restarts it
    pulse_rst();
    for (int i = 0; i < 20; i++) step();
    pulse_rst();
    wait_ready(1'b0, zeros);

    // Reset while an update sits in S1: it must never report done
    upd(1'b0, 9, 32'h55);
    done_cnt = 0;
    pulse_rst();
    wait_ready(1'b0, zeros);
    check("discard_done", done_cnt, 0);
    rd_en = 2'b01;
    rd_addr[0 +: AW] = AW'(9);
    step();
    clear_in();
    check("discard_data", rd_data[0 +: DW], 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_qmax_rmw_table
`default_nettype wire
